// File: rtl/vga_timing_gen.sv
// VGA raster timing for the pong display path: pixel divider, x/y raster counters,
// visible flag, polarity-adjusted sync with a latency-matching delay line, and frame strobes.

`ifndef X_POS_W
`define X_POS_W 10
`endif
`ifndef Y_POS_W
`define Y_POS_W 10
`endif

module vga_timing_gen #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter bit          HSYNC_POL  = 1'b0,
    parameter bit          VSYNC_POL  = 1'b0,
    parameter int unsigned SYNC_DELAY = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    output logic [`X_POS_W-1:0] vga_x_pos_o,
    output logic [`Y_POS_W-1:0] vga_y_pos_o,
    output logic                vga_visible_range_o,
    output logic                pixel_tick_o,
    output logic                vga_hsync_o,
    output logic                vga_vsync_o,
    output logic                frame_start_o,
    output logic                vblank_start_o
);

    localparam int unsigned H_TOTAL      = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL      = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FRONT;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FRONT;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam int unsigned X_W          = `X_POS_W;
    localparam int unsigned Y_W          = `Y_POS_W;
    localparam int unsigned DIV_W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic             frame_start_q, frame_start_d;
    logic             vblank_start_q, vblank_start_d;
    logic             pixel_tick, x_wrap, y_wrap;
    logic             hsync_level, vsync_level;

    // Constants are compared against zero-extended counters, never truncated.
    always_comb begin
        pixel_tick     = (div_cnt_q == DIV_LAST);
        div_cnt_d      = pixel_tick ? '0 : div_cnt_q + 1'b1;
        x_wrap         = (32'(x_q) == H_TOTAL - 1);
        y_wrap         = (32'(y_q) == V_TOTAL - 1);
        x_d            = x_q;
        y_d            = y_q;
        if (pixel_tick) begin
            x_d = x_wrap ? '0 : x_q + 1'b1;
            if (x_wrap) begin
                y_d = y_wrap ? '0 : y_q + 1'b1;
            end
        end
        frame_start_d  = pixel_tick && x_wrap && y_wrap;
        vblank_start_d = pixel_tick && x_wrap && (32'(y_q) == V_ACTIVE - 1);
        hsync_level    = ((32'(x_q) >= H_SYNC_START) && (32'(x_q) < H_SYNC_END)) ? HSYNC_POL : ~HSYNC_POL;
        vsync_level    = ((32'(y_q) >= V_SYNC_START) && (32'(y_q) < V_SYNC_END)) ? VSYNC_POL : ~VSYNC_POL;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt_q      <= '0;
            x_q            <= X_W'(H_TOTAL - 1);
            y_q            <= Y_W'(V_TOTAL - 1);
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
        end else begin
            div_cnt_q      <= div_cnt_d;
            x_q            <= x_d;
            y_q            <= y_d;
            frame_start_q  <= frame_start_d;
            vblank_start_q <= vblank_start_d;
        end
    end

    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign vga_hsync_o = hsync_level;
            assign vga_vsync_o = vsync_level;
        end else begin : g_delay
            // Bit 1 carries vsync, bit 0 hsync; advances every clk, not every pixel tick.
            logic [1:0] sync_pipe_q [SYNC_DELAY];

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int i = 0; i < int'(SYNC_DELAY); i++) begin
                        sync_pipe_q[i] <= {~VSYNC_POL, ~HSYNC_POL};
                    end
                end else begin
                    sync_pipe_q[0] <= {vsync_level, hsync_level};
                    for (int i = 1; i < int'(SYNC_DELAY); i++) begin
                        sync_pipe_q[i] <= sync_pipe_q[i-1];
                    end
                end
            end

            assign vga_hsync_o = sync_pipe_q[SYNC_DELAY-1][0];
            assign vga_vsync_o = sync_pipe_q[SYNC_DELAY-1][1];
        end
    endgenerate

    assign vga_x_pos_o         = x_q;
    assign vga_y_pos_o         = y_q;
    assign vga_visible_range_o = (32'(x_q) < H_ACTIVE) && (32'(y_q) < V_ACTIVE);
    assign pixel_tick_o        = pixel_tick;
    assign frame_start_o       = frame_start_q;
    assign vblank_start_o      = vblank_start_q;

endmodule
